fetch_sequencer: RTL and testbench

- Owns the F-stage PC register and the IF/ID pipeline register, and sequences instruction fetch against a handshaked instruction memory.
- Consumes the D-stage next-PC decision (pc_op plus precomputed targets) and the hazard unit's stall, and honours the MIPS branch delay slot.
- Sits between the next-PC logic, the hazard/stall unit and IM; it feeds instr_D/pc_D/pc4_D to decode.

---
 rtl/fetch_sequencer_if.sv | 22 ++
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory handshake between the fetch sequencer (master) and IM (slave).
// imem_addr is held stable while imem_req=1 and imem_ready=0.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// F-stage PC, IF/ID register and IM fetch sequencing with a one-entry skid buffer.
// D-stage redirects honour the MIPS branch delay slot.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [1:0]                pc_op,
    input  logic [31:0]               target_reg,
    input  logic [31:0]               target_imm,
    fetch_sequencer_if.master         imem,
    output logic [31:0]               instr_D,
    output logic [31:0]               pc_D,
    output logic [31:0]               pc4_D,
    output logic                      valid_D
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    logic        req;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        pend_valid;
    logic [31:0] pend_pc;

    logic        deliver;
    logic [31:0] dlv_word;
    logic [31:0] dlv_pc;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_adv;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign pc4_D          = pc_D + 32'd4;

    always_comb begin
        deliver  = 1'b0;
        dlv_word = buf_instr;
        dlv_pc   = buf_pc;
        case (state)
            FETCH: begin
                deliver  = imem.imem_ready && !stall;
                dlv_word = imem.imem_rdata;
                dlv_pc   = pc;
            end
            HOLD:    deliver = !stall;
            default: deliver = 1'b0;
        endcase

        redirect = valid_D && !stall && (pc_op != 2'b00);
        case (pc_op)
            2'b01:   target = target_reg;
            2'b10:   target = target_imm;
            default: target = RESET_PC;
        endcase

        // A redirect parked behind the delay slot wins over one arriving now.
        if (pend_valid)
            pc_adv = pend_pc;
        else if (redirect)
            pc_adv = target;
        else
            pc_adv = pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= BOOT;
            req        <= 1'b0;
            pc         <= RESET_PC;
            buf_instr  <= '0;
            buf_pc     <= '0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            instr_D    <= '0;
            pc_D       <= '0;
            valid_D    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ready && stall) begin
                        buf_instr <= imem.imem_rdata;
                        buf_pc    <= pc;
                        state     <= HOLD;
                        req       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= FETCH;
                        req   <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                    req   <= 1'b0;
                end
            endcase

            if (!stall) begin
                if (deliver) begin
                    instr_D <= dlv_word;
                    pc_D    <= dlv_pc;
                    valid_D <= 1'b1;
                end else begin
                    instr_D <= '0;
                    valid_D <= 1'b0;
                end
            end

            if (deliver) begin
                pc         <= pc_adv;
                pend_valid <= 1'b0;
            end else if (redirect) begin
                pend_valid <= 1'b1;
                pend_pc    <= target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot sequence, redirects, delay slot,
// skid buffer under stall, PC wrap and mid-fetch reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_op;
    logic [31:0] target_reg;
    logic [31:0] target_imm;
    logic        ready;
    logic [31:0] salt;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc4_D;
    logic        valid_D;
    logic [31:0] exp_word;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if imem_bus ();

    // IM model: word is a function of address and a changeable salt.
    assign imem_bus.imem_ready = ready;
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ salt;

    fetch_sequencer #(
        .RESET_PC(32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .pc_op     (pc_op),
        .target_reg(target_reg),
        .target_imm(target_imm),
        .imem      (imem_bus.master),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc4_D     (pc4_D),
        .valid_D   (valid_D)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, run until pc_D=0x3000 is valid and imem_addr=0x3004.
    task automatic boot();
        reset = 1'b0; stall = 1'b0; ready = 1'b1; pc_op = 2'b00; salt = 32'hA5A5_0000;
        target_reg = '0; target_imm = '0;
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; ready = 1'b1; pc_op = 2'b00; salt = 32'hA5A5_0000;
        target_reg = '0; target_imm = '0;
        cyc(); cyc();
        n_cmp++;
        if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h3000 || valid_D !== 1'b0 ||
            instr_D !== 32'h0 || pc_D !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state req=%b addr=%h valid=%b instr=%h pc=%h want 0 3000 0 0 0",
                     imem_bus.imem_req, imem_bus.imem_addr, valid_D, instr_D, pc_D);
        end
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3000 || valid_D !== 1'b0) begin
            n_bad++;
            $display("FAIL boot_fetch req=%b addr=%h valid=%b want 1 3000 0",
                     imem_bus.imem_req, imem_bus.imem_addr, valid_D);
        end
        cyc();
        exp_word = 32'h3000 ^ salt;
        n_cmp++;
        if (valid_D !== 1'b1 || pc_D !== 32'h3000 || pc4_D !== 32'h3004 || instr_D !== exp_word ||
            imem_bus.imem_addr !== 32'h3004) begin
            n_bad++;
            $display("FAIL first_deliver valid=%b pc=%h pc4=%h instr=%h addr=%h want 1 3000 3004 %h 3004",
                     valid_D, pc_D, pc4_D, instr_D, imem_bus.imem_addr, exp_word);
        end
        cyc();
        n_cmp++;
        if (imem_bus.imem_addr !== 32'h3008 || pc_D !== 32'h3004 || valid_D !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_fetch addr=%h pc=%h valid=%b want 3008 3004 1",
                     imem_bus.imem_addr, pc_D, valid_D);
        end
    endtask

    task automatic test_branch_zero_wait();
        boot();
        cyc(); cyc();
        pc_op = 2'b10; target_imm = 32'h3100;
        cyc();
        pc_op = 2'b00;
        exp_word = 32'h300C ^ salt;
        n_cmp++;
        if (pc_D !== 32'h300C || instr_D !== exp_word || valid_D !== 1'b1 || imem_bus.imem_addr !== 32'h3100) begin
            n_bad++;
            $display("FAIL branch_delay_slot pc=%h instr=%h valid=%b addr=%h want 300c %h 1 3100",
                     pc_D, instr_D, valid_D, imem_bus.imem_addr, exp_word);
        end
        cyc();
        n_cmp++;
        if (pc_D !== 32'h3100 || imem_bus.imem_addr !== 32'h3104) begin
            n_bad++;
            $display("FAIL branch_target pc=%h addr=%h want 3100 3104", pc_D, imem_bus.imem_addr);
        end
    endtask

    task automatic test_branch_pending();
        boot();
        cyc(); cyc();
        pc_op = 2'b10; target_imm = 32'h3100; ready = 1'b0;
        cyc();
        target_imm = 32'h3200;  // must be ignored: valid_D is 0 from here on
        n_cmp++;
        if (valid_D !== 1'b0 || instr_D !== 32'h0 || pc_D !== 32'h3008 || imem_bus.imem_addr !== 32'h300C ||
            imem_bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL pend_bubble valid=%b instr=%h pc=%h addr=%h req=%b want 0 0 3008 300c 1",
                     valid_D, instr_D, pc_D, imem_bus.imem_addr, imem_bus.imem_req);
        end
        cyc(); cyc();
        n_cmp++;
        if (valid_D !== 1'b0 || imem_bus.imem_addr !== 32'h300C) begin
            n_bad++;
            $display("FAIL pend_wait valid=%b addr=%h want 0 300c", valid_D, imem_bus.imem_addr);
        end
        ready = 1'b1;
        cyc();
        pc_op = 2'b00;
        n_cmp++;
        if (valid_D !== 1'b1 || pc_D !== 32'h300C || imem_bus.imem_addr !== 32'h3100) begin
            n_bad++;
            $display("FAIL pend_apply valid=%b pc=%h addr=%h want 1 300c 3100",
                     valid_D, pc_D, imem_bus.imem_addr);
        end
        cyc();
        n_cmp++;
        if (pc_D !== 32'h3100 || imem_bus.imem_addr !== 32'h3104) begin
            n_bad++;
            $display("FAIL pend_cleared pc=%h addr=%h want 3100 3104", pc_D, imem_bus.imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] buffered;
        boot();
        cyc(); cyc(); cyc();
        stall = 1'b1;
        buffered = 32'h3010 ^ salt;
        cyc();
        salt = 32'h0F0F_1234;  // live IM word now differs from the buffered one
        n_cmp++;
        if (imem_bus.imem_req !== 1'b0 || pc_D !== 32'h300C || valid_D !== 1'b1 ||
            imem_bus.imem_addr !== 32'h3010) begin
            n_bad++;
            $display("FAIL hold_enter req=%b pc=%h valid=%b addr=%h want 0 300c 1 3010",
                     imem_bus.imem_req, pc_D, valid_D, imem_bus.imem_addr);
        end
        cyc();
        stall = 1'b0;
        n_cmp++;
        if (imem_bus.imem_req !== 1'b0 || pc_D !== 32'h300C || instr_D !== (32'h300C ^ 32'hA5A5_0000)) begin
            n_bad++;
            $display("FAIL hold_frozen req=%b pc=%h instr=%h want 0 300c %h",
                     imem_bus.imem_req, pc_D, instr_D, 32'h300C ^ 32'hA5A5_0000);
        end
        cyc();
        n_cmp++;
        if (pc_D !== 32'h3010 || instr_D !== buffered || valid_D !== 1'b1 ||
            imem_bus.imem_addr !== 32'h3014 || imem_bus.imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release pc=%h instr=%h valid=%b addr=%h req=%b want 3010 %h 1 3014 1",
                     pc_D, instr_D, valid_D, imem_bus.imem_addr, imem_bus.imem_req, buffered);
        end
    endtask

    task automatic test_jr_and_reset_op();
        boot();
        cyc(); cyc();
        stall = 1'b1; pc_op = 2'b01; target_reg = 32'h3080;
        cyc(); cyc();
        n_cmp++;
        if (pc_D !== 32'h3008 || imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h300C) begin
            n_bad++;
            $display("FAIL jr_stalled pc=%h req=%b addr=%h want 3008 0 300c",
                     pc_D, imem_bus.imem_req, imem_bus.imem_addr);
        end
        stall = 1'b0; target_reg = 32'h3040;
        cyc();
        pc_op = 2'b11;
        n_cmp++;
        if (pc_D !== 32'h300C || valid_D !== 1'b1 || imem_bus.imem_addr !== 32'h3040) begin
            n_bad++;
            $display("FAIL jr_taken pc=%h valid=%b addr=%h want 300c 1 3040",
                     pc_D, valid_D, imem_bus.imem_addr);
        end
        cyc();
        pc_op = 2'b00;
        n_cmp++;
        if (pc_D !== 32'h3040 || imem_bus.imem_addr !== 32'h3000) begin
            n_bad++;
            $display("FAIL op_reset_pc pc=%h addr=%h want 3040 3000", pc_D, imem_bus.imem_addr);
        end
        cyc();
        n_cmp++;
        if (pc_D !== 32'h3000 || imem_bus.imem_addr !== 32'h3004) begin
            n_bad++;
            $display("FAIL after_reset_pc pc=%h addr=%h want 3000 3004", pc_D, imem_bus.imem_addr);
        end
    endtask

    task automatic test_pc_wrap();
        boot();
        cyc(); cyc();
        pc_op = 2'b10; target_imm = 32'hFFFF_FFFC;
        cyc();
        pc_op = 2'b00;
        cyc();
        n_cmp++;
        if (pc_D !== 32'hFFFF_FFFC || pc4_D !== 32'h0 || imem_bus.imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL pc_wrap pc=%h pc4=%h addr=%h want fffffffc 0 0",
                     pc_D, pc4_D, imem_bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        boot();
        ready = 1'b0;
        cyc();
        reset = 1'b0; ready = 1'b1;  // stale completion while in reset
        cyc();
        n_cmp++;
        if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h3000 || valid_D !== 1'b0 ||
            instr_D !== 32'h0 || pc_D !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset req=%b addr=%h valid=%b instr=%h pc=%h want 0 3000 0 0 0",
                     imem_bus.imem_req, imem_bus.imem_addr, valid_D, instr_D, pc_D);
        end
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3000 || valid_D !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_boot req=%b addr=%h valid=%b want 1 3000 0",
                     imem_bus.imem_req, imem_bus.imem_addr, valid_D);
        end
        cyc();
        n_cmp++;
        if (valid_D !== 1'b1 || pc_D !== 32'h3000 || imem_bus.imem_addr !== 32'h3004) begin
            n_bad++;
            $display("FAIL mid_reset_first valid=%b pc=%h addr=%h want 1 3000 3004",
                     valid_D, pc_D, imem_bus.imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_branch_zero_wait();
        test_branch_pending();
        test_stall_hold();
        test_jr_and_reset_op();
        test_pc_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
